// File: rtl/ec_point_encoder_if.sv
// Point-in / byte-out handshake bundle between the scalar-multiply core,
// the SEC1 point encoder and the byte-oriented export stream.
interface ec_point_encoder_if #(
    parameter int COORD_BYTES = 32
);
    localparam int CNT_W = $clog2(2 * COORD_BYTES + 1);

    logic                     in_valid;
    logic                     in_ready;
    logic [8*COORD_BYTES-1:0] in_x;
    logic [8*COORD_BYTES-1:0] in_y;
    logic                     in_inf;
    logic [2:0]               in_mode;
    logic                     out_valid;
    logic                     out_ready;
    logic [7:0]               out_data;
    logic                     out_last;
    logic [CNT_W-1:0]         out_len;
    logic                     err;
    logic                     busy;

    modport master (
        output in_valid, in_x, in_y, in_inf, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_len, err, busy
    );

    modport slave (
        input  in_valid, in_x, in_y, in_inf, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_last, out_len, err, busy
    );
endinterface

// File: rtl/ec_point_encoder.sv
// Serialises one affine EC point into a SEC1 octet stream (compressed,
// uncompressed, hybrid or infinity), one byte per handshake, MSB first.
module ec_point_encoder #(
    parameter int COORD_BYTES = 32
) (
    input  logic               clk,
    input  logic               rst,
    ec_point_encoder_if.slave  bus
);
    localparam int CNT_W = $clog2(2 * COORD_BYTES + 1);
    localparam int XW    = 8 * COORD_BYTES;
    localparam logic [CNT_W-1:0] LP_TERM     = CNT_W'(COORD_BYTES - 1);
    localparam logic [CNT_W-1:0] LP_LEN_COMP = CNT_W'(COORD_BYTES + 1);
    localparam logic [CNT_W-1:0] LP_LEN_FULL = CNT_W'(2 * COORD_BYTES + 1);

    // DONE marks that the byte currently presented is the final one.
    typedef enum logic [2:0] {S_IDLE, S_PREFIX, S_XB, S_YB, S_DONE} state_t;

    state_t           r_state;
    logic [XW-1:0]    r_x;
    logic [XW-1:0]    r_y;
    logic             r_comp;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [7:0]       r_out_data;
    logic             r_out_last;
    logic [CNT_W-1:0] r_out_len;
    logic             r_err;
    logic             r_busy;

    logic             w_accept;
    logic             w_legal;
    logic             w_advance;
    logic             w_cnt_term;
    logic             w_next_term;
    logic             w_single;
    logic [CNT_W-1:0] w_cnt_next;
    logic [7:0]       w_prefix;

    assign w_accept    = bus.in_valid && r_in_ready;
    assign w_legal     = (bus.in_mode == 3'd2) || (bus.in_mode == 3'd4) || (bus.in_mode == 3'd6);
    assign w_advance   = r_out_valid && bus.out_ready;
    assign w_cnt_next  = r_cnt + 1'b1;
    assign w_cnt_term  = (r_cnt == LP_TERM);
    assign w_next_term = (w_cnt_next == LP_TERM);
    assign w_single    = (LP_TERM == '0);

    always_comb begin
        // NOTE: default first so every path assigns w_prefix and no latch is inferred.
        w_prefix = 8'h04;
        case (bus.in_mode)
            3'd2:    w_prefix = 8'h02 | {7'd0, bus.in_y[0]};
            3'd6:    w_prefix = 8'h06 | {7'd0, bus.in_y[0]};
            default: w_prefix = 8'h04;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_comp      <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_out_last  <= 1'b0;
            r_out_len   <= '0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere here so all state updates see pre-edge values.
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (bus.in_inf) begin
                            r_out_data  <= 8'h00;
                            r_out_valid <= 1'b1;
                            r_out_last  <= 1'b1;
                            r_out_len   <= CNT_W'(1);
                            r_in_ready  <= 1'b0;
                            r_busy      <= 1'b1;
                            r_state     <= S_DONE;
                        end else if (w_legal) begin
                            r_x         <= bus.in_x;
                            r_y         <= bus.in_y;
                            r_comp      <= (bus.in_mode == 3'd2);
                            r_out_data  <= w_prefix;
                            r_out_valid <= 1'b1;
                            r_out_last  <= 1'b0;
                            r_out_len   <= (bus.in_mode == 3'd2) ? LP_LEN_COMP : LP_LEN_FULL;
                            r_in_ready  <= 1'b0;
                            r_busy      <= 1'b1;
                            r_state     <= S_PREFIX;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_PREFIX: begin
                    if (w_advance) begin
                        r_out_data <= r_x[XW-1 -: 8];
                        r_x        <= r_x << 8;
                        r_cnt      <= '0;
                        r_out_last <= r_comp && w_single;
                        r_state    <= (r_comp && w_single) ? S_DONE : S_XB;
                    end
                end
                S_XB: begin
                    if (w_advance) begin
                        if (w_cnt_term) begin
                            r_out_data <= r_y[XW-1 -: 8];
                            r_y        <= r_y << 8;
                            r_cnt      <= '0;
                            r_out_last <= w_single;
                            r_state    <= w_single ? S_DONE : S_YB;
                        end else begin
                            r_out_data <= r_x[XW-1 -: 8];
                            r_x        <= r_x << 8;
                            r_cnt      <= w_cnt_next;
                            r_out_last <= r_comp && w_next_term;
                            r_state    <= (r_comp && w_next_term) ? S_DONE : S_XB;
                        end
                    end
                end
                S_YB: begin
                    if (w_advance) begin
                        r_out_data <= r_y[XW-1 -: 8];
                        r_y        <= r_y << 8;
                        r_cnt      <= w_cnt_next;
                        r_out_last <= w_next_term;
                        r_state    <= w_next_term ? S_DONE : S_YB;
                    end
                end
                S_DONE: begin
                    if (w_advance) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.out_len   = r_out_len;
    assign bus.err       = r_err;
    assign bus.busy      = r_busy;
endmodule
